// File: rtl/truth_table_sweeper.sv
// Programmable N-input Boolean function held in a loadable 2^N-bit truth table.
// It gives a registered lookup, plus a valid/ready sweep that streams every minterm and counts the ones.
module truth_table_sweeper #(
    parameter int                N          = 4,
    parameter logic [(1<<N)-1:0] TT_DEFAULT = 16'hFDFD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [(1<<N)-1:0] tt_in,
    input  logic [N-1:0]      in_vec,
    output logic              f,
    input  logic              start,
    output logic              busy,
    output logic              sweep_valid,
    input  logic              sweep_ready,
    output logic [N-1:0]      sweep_idx,
    output logic              sweep_f,
    output logic              done,
    output logic [N:0]        ones_count
);
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    state_t            state;
    logic [(1<<N)-1:0] tt;
    logic [N:0]        count;
    logic [N-1:0]      idx_nxt;
    logic              xfer;

    assign xfer    = sweep_valid & sweep_ready;
    assign idx_nxt = sweep_idx + N'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tt          <= TT_DEFAULT;
            count       <= '0;
            f           <= 1'b0;
            busy        <= 1'b0;
            sweep_valid <= 1'b0;
            sweep_idx   <= '0;
            sweep_f     <= 1'b0;
            done        <= 1'b0;
            ones_count  <= '0;
        end else begin
            f    <= tt[in_vec];
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load)
                        tt <= tt_in;
                    if (start) begin
                        state       <= S_SWEEP;
                        sweep_idx   <= '0;
                        // A simultaneous load must already be visible to beat 0.
                        sweep_f     <= load ? tt_in[0] : tt[0];
                        count       <= '0;
                        sweep_valid <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (xfer) begin
                        count <= count + (N+1)'(sweep_f);
                        if (sweep_idx == '1) begin
                            state       <= S_DONE;
                            sweep_valid <= 1'b0;
                        end else begin
                            sweep_idx <= idx_nxt;
                            sweep_f   <= tt[idx_nxt];
                        end
                    end
                end
                S_DONE: begin
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    ones_count <= count;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: stimulus pushes expected beats/done into queues and monitors pop them.
// A second instance covers N=2 with an XOR table.
module tb_truth_table_sweeper;
    typedef struct { int idx; int fv; } beat_t;
    typedef struct { int ones; int cyc; } done_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0, start = 1'b0, sweep_ready = 1'b0;
    logic [15:0] tt_in = '0;
    logic [3:0]  in_vec = '0;
    logic        f, busy, sweep_valid, sweep_f, done;
    logic [3:0]  sweep_idx;
    logic [4:0]  ones_count;

    logic        load2 = 1'b0, start2 = 1'b0, ready2 = 1'b0;
    logic [3:0]  tt_in2 = '0;
    logic [1:0]  in_vec2 = '0;
    logic        f2, busy2, valid2, sf2, done2;
    logic [1:0]  idx2;
    logic [2:0]  ones2;

    int total = 0, bad = 0, cyc = 0;
    logic [15:0] m_tt = 16'hFDFD;
    logic [15:0] tt_def = 16'hFDFD;
    logic [3:0]  xor_tt = 4'b0110;
    int last_ones = 0;
    beat_t beat_q[$];
    done_t done_q[$];
    int b2 = 0, done2_seen = 0, exp_done2 = 0;

    truth_table_sweeper #(.N(4), .TT_DEFAULT(16'hFDFD)) dut (
        .clk(clk), .rst(rst), .load(load), .tt_in(tt_in), .in_vec(in_vec), .f(f),
        .start(start), .busy(busy), .sweep_valid(sweep_valid), .sweep_ready(sweep_ready),
        .sweep_idx(sweep_idx), .sweep_f(sweep_f), .done(done), .ones_count(ones_count)
    );

    truth_table_sweeper #(.N(2), .TT_DEFAULT(4'b0110)) dut2 (
        .clk(clk), .rst(rst), .load(load2), .tt_in(tt_in2), .in_vec(in_vec2), .f(f2),
        .start(start2), .busy(busy2), .sweep_valid(valid2), .sweep_ready(ready2),
        .sweep_idx(idx2), .sweep_f(sf2), .done(done2), .ones_count(ones2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor for the N=4 instance.
    initial begin
        bit   stall_prev;
        int   p_idx, p_f;
        beat_t b;
        done_t d;
        stall_prev = 0; p_idx = 0; p_f = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    chk("stall_valid", int'(sweep_valid), 1);
                    chk("stall_idx", int'(sweep_idx), p_idx);
                    chk("stall_f", int'(sweep_f), p_f);
                end
                if (sweep_valid && sweep_ready) begin
                    if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
                    else begin
                        b = beat_q.pop_front();
                        chk("beat_idx", int'(sweep_idx), b.idx);
                        chk("beat_f", int'(sweep_f), b.fv);
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                    else begin
                        d = done_q.pop_front();
                        chk("ones_count", int'(ones_count), d.ones);
                        chk("done_cycle", cyc, d.cyc);
                        chk("busy_at_done", int'(busy), 0);
                        chk("valid_at_done", int'(sweep_valid), 0);
                    end
                end
                stall_prev = sweep_valid && !sweep_ready;
                p_idx = int'(sweep_idx);
                p_f   = int'(sweep_f);
            end
        end
    end

    // Monitor for the N=2 instance.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (valid2 && ready2) begin
                    chk("n2_idx", int'(idx2), b2 % 4);
                    chk("n2_f", int'(sf2), int'(xor_tt[b2 % 4]));
                    b2++;
                end
                if (done2) begin
                    chk("n2_ones", int'(ones2), 2);
                    chk("n2_done_cycle", cyc, exp_done2);
                    done2_seen++;
                end
            end
        end
    end

    task automatic fcheck(input logic [3:0] v);
        in_vec = v;
        @(posedge clk); #1;
        chk($sformatf("f[%0d]", v), int'(f), int'(m_tt[v]));
    endtask

    // mode: 0 ready held high, 1 toggling 1,0,..., 2 random
    task automatic sweep(input int mode, input bit do_load, input logic [15:0] tv, input int mid_load_at);
        int rem, e, t, i, ones;
        bit r;
        if (do_load) begin load = 1'b1; tt_in = tv; m_tt = tv; end
        start = 1'b1;
        t = cyc + 1;
        for (int k = 0; k < 16; k++) beat_q.push_back('{k, int'(m_tt[k])});
        ones = $countones(m_tt);
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0;
        rem = 16; e = t; i = 0;
        while (rem > 0) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
            sweep_ready = r;
            e++;
            if (r) rem--;
            if (i == mid_load_at) begin load = 1'b1; tt_in = 16'h0000; end
            else load = 1'b0;
            i++;
            @(posedge clk); #1;
        end
        load = 1'b0;
        done_q.push_back('{ones, e + 1});
        last_ones = ones;
        repeat (3) @(posedge clk);
        #1;
        chk("done_pending", done_q.size(), 0);
        chk("beats_pending", beat_q.size(), 0);
        chk("ones_hold", int'(ones_count), last_ones);
    endtask

    initial begin
        int t;
        logic [15:0] rt;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_f", int'(f), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(sweep_valid), 0);
        chk("rst_idx", int'(sweep_idx), 0);
        chk("rst_sweep_f", int'(sweep_f), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ones", int'(ones_count), 0);

        for (int v = 0; v < 16; v++) fcheck(4'(v));

        sweep(0, 1'b0, 16'h0, -1);              // default table: 14 ones
        sweep(1, 1'b1, 16'h0001, -1);           // toggling ready
        sweep(0, 1'b1, 16'hFFFF, 5);            // load+start, mid-sweep load ignored
        sweep(2, 1'b0, 16'h0, -1);              // still all ones

        for (int n = 0; n < 4; n++) begin
            rt = 16'($urandom);
            load = 1'b1; tt_in = rt;
            @(posedge clk); #1;
            load = 1'b0; m_tt = rt;
            repeat (5) fcheck(4'($urandom_range(0, 15)));
            sweep(2, 1'b0, 16'h0, -1);
        end
        sweep(2, 1'b1, 16'($urandom), int'($urandom_range(0, 10)));

        // Reset while beat 7 is presented.
        load = 1'b1; tt_in = 16'h00FF; m_tt = 16'h00FF;
        start = 1'b1; sweep_ready = 1'b1;
        t = cyc + 1;
        for (int k = 0; k < 7; k++) beat_q.push_back('{k, int'(m_tt[k])});
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0;
        while (cyc < t + 7) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        beat_q.delete(); done_q.delete();
        m_tt = tt_def;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(sweep_valid), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ones", int'(ones_count), 0);
        chk("abort_beats_left", beat_q.size(), 0);
        @(posedge clk); #1;
        sweep_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        fcheck(4'd9);
        fcheck(4'd3);
        sweep(0, 1'b0, 16'h0, -1);              // table back to default

        // N=2 XOR instance
        ready2 = 1'b1; start2 = 1'b1;
        exp_done2 = cyc + 1 + 5;
        b2 = 0;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("n2_beats", b2, 4);
        chk("n2_done_seen", done2_seen, 1);
        in_vec2 = 2'd2;
        @(posedge clk); #1;
        chk("n2_f", int'(f2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
